// File: rtl/uart_cmd_parser_if.sv
// Byte stream from the UART receiver and the command request/error outputs of the parser.
// master = the parser, slave = the UART/downstream side.
interface uart_cmd_parser_if;
  logic        uart_done;
  logic [7:0]  uart_data;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        err_opcode;
  logic        err_overrun;
  logic        err_timeout;

  modport master (
    input  uart_done, uart_data, req_ready,
    output req_valid, req_write, req_addr, req_wdata,
    output err_opcode, err_overrun, err_timeout
  );

  modport slave (
    output uart_done, uart_data, req_ready,
    input  req_valid, req_write, req_addr, req_wdata,
    input  err_opcode, err_overrun, err_timeout
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Turns a UART byte stream ('W'/'R' + 4 addr bytes [+ 4 data bytes]) into 32-bit requests.
// Define UART_CMD_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle cycles.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_cmd_parser_if.master bus
);
  // state | meaning
  // IDLE  | waiting for an opcode byte
  // ADDR  | collecting 4 address bytes, MSB first
  // DATA  | collecting 4 write-data bytes, MSB first
  // ISSUE | request presented, waiting for req_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_range
    $error("uart_cmd_parser: TIMEOUT_CYCLES must be non-zero");
  end

  state_t      state_q, state_d;
  logic [1:0]  idx_q;
  logic        done_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_valid_q;
  logic        err_opcode_q;
  logic        err_overrun_q;

  logic strobe;
  logic is_op;
  logic last_byte;
  logic handshake;
  logic timeout_hit;

  logic latch_op;
  logic shift_addr;
  logic shift_data;
  logic clear_frame;
  logic err_opcode_d;
  logic err_overrun_d;

  assign strobe    = bus.uart_done & ~done_q;
  assign is_op     = (bus.uart_data == OP_WRITE) || (bus.uart_data == OP_READ);
  assign last_byte = (idx_q == 2'd3);
  assign handshake = req_valid_q & bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= bus.uart_done;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (strobe && is_op) state_d = ADDR;
      end
      ADDR: begin
        if (timeout_hit) state_d = IDLE;
        else if (strobe && last_byte) state_d = write_q ? DATA : ISSUE;
      end
      DATA: begin
        if (timeout_hit) state_d = IDLE;
        else if (strobe && last_byte) state_d = ISSUE;
      end
      ISSUE: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A strobe in ISSUE, including the handshake cycle, is dropped rather than parsed.
  always_comb begin
    latch_op      = 1'b0;
    shift_addr    = 1'b0;
    shift_data    = 1'b0;
    clear_frame   = 1'b0;
    err_opcode_d  = 1'b0;
    err_overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (is_op) latch_op = 1'b1;
          else       err_opcode_d = 1'b1;
        end
      end
      ADDR: begin
        if (timeout_hit) clear_frame = 1'b1;
        else if (strobe) shift_addr = 1'b1;
      end
      DATA: begin
        if (timeout_hit) clear_frame = 1'b1;
        else if (strobe) shift_data = 1'b1;
      end
      ISSUE: begin
        if (strobe) err_overrun_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= 2'd0;
      write_q       <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      req_valid_q   <= 1'b0;
      err_opcode_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      req_valid_q   <= (state_d == ISSUE);
      err_opcode_q  <= err_opcode_d;
      err_overrun_q <= err_overrun_d;
      if (latch_op) begin
        write_q <= (bus.uart_data == OP_WRITE);
        idx_q   <= 2'd0;
        addr_q  <= 32'd0;
        wdata_q <= 32'd0;
      end else if (clear_frame) begin
        idx_q   <= 2'd0;
        addr_q  <= 32'd0;
        wdata_q <= 32'd0;
      end else begin
        if (shift_addr) addr_q  <= {addr_q[23:0], bus.uart_data};
        if (shift_data) wdata_q <= {wdata_q[23:0], bus.uart_data};
        if (shift_addr || shift_data) idx_q <= idx_q + 2'd1;
      end
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] to_cnt_q;
  logic        collecting;
  logic        err_timeout_q;

  assign collecting  = (state_q == ADDR) || (state_q == DATA);
  assign timeout_hit = collecting && !strobe && (to_cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= 32'd0;
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= timeout_hit;
      if (strobe || !collecting || timeout_hit) to_cnt_q <= 32'd0;
      else                                      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end

  assign bus.err_timeout = err_timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.req_valid   = req_valid_q;
  assign bus.req_write   = write_q;
  assign bus.req_addr    = addr_q;
  assign bus.req_wdata   = wdata_q;
  assign bus.err_opcode  = err_opcode_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65536: inter-byte timeout in clk cycles (used only when the timeout feature is compiled in).
REQ-002 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port uart_done, input, 1: level byte-valid from the UART receiver; may stay high for many cycles per byte.
REQ-005 SHALL have port uart_data, input, 8: received byte, valid while uart_done is high.
REQ-006 SHALL have port req_valid, output, 1: command request pending.
REQ-007 SHALL have port req_ready, input, 1: downstream accepts the request.
REQ-008 SHALL have port req_write, output, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, output, 32: command address.
REQ-010 SHALL have port req_wdata, output, 32: write data; 0 for reads.
REQ-011 SHALL have port err_opcode, output, 1: one-cycle pulse when an unknown opcode byte is received.
REQ-012 SHALL have port err_overrun, output, 1: one-cycle pulse when a byte is dropped.
REQ-013 SHALL have port err_timeout, output, 1: one-cycle pulse when a frame is abandoned on timeout; tied 0 when the timeout feature is compiled out.

Function
REQ-014 SHALL accept exactly one byte per rising edge of uart_done:
- uart_done is registered once; byte strobe = uart_done & ~uart_done_q.
- uart_data is sampled in the cycle of the strobe.
REQ-015 SHALL parse frames of the following format:
- Opcode byte: 0x57 ('W') = write, 0x52 ('R') = read.
- Then 4 address bytes, MSB first.
- Write frames only: then 4 data bytes, MSB first.
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA and ISSUE, with a 2-bit byte index.
REQ-017 IDLE: on strobe with 0x57 or 0x52 -> ADDR, latch req_write, index = 0; any other byte -> stay in IDLE and pulse err_opcode the next cycle.
REQ-018 ADDR: each strobe shifts the byte into addr[7:0] (addr <= {addr[23:0], byte}); on index 3 -> DATA if write, else ISSUE with wdata = 0.
REQ-019 DATA: each strobe shifts the byte into wdata the same way; on index 3 -> ISSUE.
REQ-020 ISSUE: req_valid = 1, with req_write, req_addr and req_wdata stable until the handshake; on req_valid & req_ready -> IDLE, req_valid = 0 the next cycle.
REQ-021 Request latency: req_valid SHALL rise the cycle after the final byte's strobe.
REQ-022 A strobe in ISSUE SHALL drop the byte and pulse err_overrun; the request is unaffected.
REQ-023 A strobe in the same cycle as the handshake SHALL also be dropped with err_overrun; it is not treated as a new opcode.
REQ-024 Outputs SHALL be registered; error pulses are exactly one cycle wide.
REQ-025 Opcode compare SHALL be exact 8-bit; lowercase 'w'/'r' are errors.

Reset
REQ-026 On rst_n low, at any time and mid-frame included, the block SHALL asynchronously reset to:
- FSM = IDLE, index = 0, uart_done_q = 0.
- req_valid = 0, req_write = 0, req_addr = 0, req_wdata = 0.
- All err_* = 0; timeout counter = 0.
REQ-027 After reset release, the first byte SHALL be interpreted as an opcode; a uart_done already high at release counts as a rising edge only if it was low in the first registered cycle.

Configuration
REQ-028 Macro UART_CMD_TIMEOUT_EN SHALL compile the inter-byte timeout in or out.
REQ-029 With UART_CMD_TIMEOUT_EN defined:
- A 32-bit counter clears on every strobe and increments in ADDR/DATA.
- On reaching TIMEOUT_CYCLES-1 -> IDLE, index = 0, partial addr/wdata discarded, err_timeout pulsed.
- The counter is held at 0 in IDLE and ISSUE.
REQ-030 Without UART_CMD_TIMEOUT_EN: no counter is instantiated, a partial frame waits indefinitely, and err_timeout = 0.

Verification
REQ-031 Write frame 57 12 34 56 78 DE AD BE EF, req_ready = 1 -> one request: write = 1, addr = 0x12345678, wdata = 0xDEADBEEF, req_valid high for exactly 1 cycle.
REQ-032 Read frame 52 00 00 10 04 with uart_done held 20 cycles per byte -> exactly one request: write = 0, addr = 0x00001004, wdata = 0; no extra bytes consumed.
REQ-033 Byte 0x41, then frame 52 AA BB CC DD -> err_opcode pulse once, then a read to 0xAABBCCDD.
REQ-034 Write frame completed with req_ready = 0 for 50 cycles while byte 0x57 arrives -> err_overrun pulse, outputs stable; after ready, state = IDLE, no write pending.
REQ-035 With UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES = 100: bytes 57 11 22, then idle 100 cycles -> err_timeout pulse, IDLE; next frame 52 01 02 03 04 -> read to 0x01020304.
REQ-036 rst_n asserted after 57 11 -> all outputs 0 immediately; after release, frame 52 00 00 00 08 -> read to 0x00000008.
